// File: rtl/uart_axi_pkg.sv
// Shared types and register map for the AXI UART streaming transmit master.
package uart_axi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        GAP,
        WR,
        WR_RESP
    } state_t;

    localparam logic [3:0] REG_TX_OFFSET   = 4'h0;
    localparam logic [3:0] REG_RX_OFFSET   = 4'h4;
    localparam logic [3:0] REG_STAT_OFFSET = 4'h8;
    localparam logic [3:0] REG_CTRL_OFFSET = 4'hC;

    localparam int         TX_BUSY_BIT   = 0;
    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/uart_axi_tx_master.sv
// AXI4-Lite master streaming bytes into the UART TX register after polling for TX idle.
// Optional response checking (err port) is enabled by defining UART_AXI_MASTER_RESP_CHECK_EN.
module uart_axi_tx_master
    import uart_axi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h44A0_0000,
    parameter logic [3:0]  TX_OFFSET   = REG_TX_OFFSET,
    parameter logic [3:0]  STAT_OFFSET = REG_STAT_OFFSET,
    parameter int          POLL_GAP    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] m_axi_awaddr,
    output logic [2:0]  m_axi_awprot,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [31:0] m_axi_araddr,
    output logic [2:0]  m_axi_arprot,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    output logic        busy,
    output logic [15:0] sent_count
`ifdef UART_AXI_MASTER_RESP_CHECK_EN
    ,
    output logic        err
`endif
);

    localparam logic [31:0] TX_ADDR   = BASE_ADDR + {28'h0, TX_OFFSET};
    localparam logic [31:0] STAT_ADDR = BASE_ADDR + {28'h0, STAT_OFFSET};
    localparam int          GAP_W     = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(POLL_GAP - 1);

    state_t           state;
    state_t           state_next;
    logic [7:0]       byte_q;
    logic [GAP_W-1:0] gap_cnt;
    logic             aw_done;
    logic             w_done;
    logic             aw_hs;
    logic             w_hs;
    logic             b_hs;
    logic             tx_busy;
    logic             b_ok;
    logic             unused_resp;

    assign aw_hs        = m_axi_awvalid & m_axi_awready;
    assign w_hs         = m_axi_wvalid & m_axi_wready;
    assign b_hs         = m_axi_bvalid & m_axi_bready;
    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;
    assign m_axi_wstrb  = 4'b0001;

`ifdef UART_AXI_MASTER_RESP_CHECK_EN
    // A failed status read cannot prove the transmitter is idle, so poll again.
    assign tx_busy     = m_axi_rdata[TX_BUSY_BIT] | (m_axi_rresp != AXI_RESP_OKAY);
    assign b_ok        = (m_axi_bresp == AXI_RESP_OKAY);
    assign unused_resp = ^m_axi_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if ((b_hs && !b_ok) ||
                     (m_axi_rvalid && m_axi_rready && m_axi_rresp != AXI_RESP_OKAY)) begin
            err <= 1'b1;
        end
    end
`else
    assign tx_busy     = m_axi_rdata[TX_BUSY_BIT];
    assign b_ok        = 1'b1;
    assign unused_resp = ^{m_axi_rdata, m_axi_rresp, m_axi_bresp};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)      state_next = RD_ADDR;
            RD_ADDR: if (m_axi_arready) state_next = RD_DATA;
            RD_DATA: if (m_axi_rvalid)  state_next = tx_busy ? GAP : WR;
            GAP:     if (gap_cnt == '0) state_next = RD_ADDR;
            WR:      if ((aw_done || aw_hs) && (w_done || w_hs)) state_next = WR_RESP;
            WR_RESP: if (m_axi_bvalid)  state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    // Write-channel done flags are only meaningful inside WR and clear on any other state.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_q     <= 8'h00;
            gap_cnt    <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            sent_count <= 16'h0000;
        end else begin
            if (state == IDLE && in_valid) begin
                byte_q <= in_data;
            end
            if (state == RD_DATA) begin
                gap_cnt <= GAP_LOAD;
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
            if (state == WR) begin
                if (aw_hs) aw_done <= 1'b1;
                if (w_hs)  w_done  <= 1'b1;
            end else begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (b_hs && b_ok) begin
                sent_count <= sent_count + 16'd1;
            end
        end
    end

    always_comb begin
        in_ready      = 1'b0;
        busy          = 1'b1;
        m_axi_arvalid = 1'b0;
        m_axi_araddr  = 32'h0;
        m_axi_rready  = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_awaddr  = 32'h0;
        m_axi_wvalid  = 1'b0;
        m_axi_wdata   = 32'h0;
        m_axi_bready  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            RD_ADDR: begin
                m_axi_arvalid = 1'b1;
                m_axi_araddr  = STAT_ADDR;
            end
            RD_DATA: m_axi_rready = 1'b1;
            WR: begin
                m_axi_awvalid = !aw_done;
                m_axi_awaddr  = TX_ADDR;
                m_axi_wvalid  = !w_done;
                m_axi_wdata   = {24'h0, byte_q};
            end
            WR_RESP: m_axi_bready = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uart_axi_tx_master.sv
// Bench for uart_axi_tx_master: vector table, AXI-Lite slave model with write scoreboard.
module tb_uart_axi_tx_master;

    localparam logic [31:0] TX_A   = 32'h44A0_0000;
    localparam logic [31:0] STAT_A = 32'h44A0_0008;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready = 1'b0;
    logic [1:0]  bresp = 2'b00;
    logic        bvalid = 1'b0;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic [1:0]  rresp = 2'b00;
    logic        rvalid = 1'b0;
    logic        rready;
    logic        busy;
    logic [15:0] sent_count;
`ifdef UART_AXI_MASTER_RESP_CHECK_EN
    logic        err;
    logic        exp_err = 1'b0;
`endif

    always #5 clk = ~clk;

    uart_axi_tx_master dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
        .busy(busy), .sent_count(sent_count)
`ifdef UART_AXI_MASTER_RESP_CHECK_EN
        , .err(err)
`endif
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Slave model configuration and state
    int          cfg_aw_wait = 0;
    int          cfg_w_wait  = 0;
    logic [1:0]  cfg_bresp   = 2'b00;
    bit          cfg_b_hold  = 1'b0;
    int          busy_left   = 0;
    int          ar_count    = 0;
    int          viol        = 0;
    int          aw_cnt = 0, w_cnt = 0, aw_seen = 0, w_seen = 0;
    bit          r_pend = 1'b0, b_pend = 1'b0, p_awv = 1'b0, p_wv = 1'b0;
    logic [31:0] p_awaddr = 32'h0, p_wdata = 32'h0;
    logic [31:0] got_awaddr = 32'h0, got_wdata = 32'h0;
    logic [3:0]  got_wstrb = 4'h0;
    logic [15:0] exp_sent = 16'h0;
    logic [31:0] sb[$];

    // Slave drives its outputs on the falling edge; handshakes complete on the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
            r_pend = 1'b0; b_pend = 1'b0; aw_cnt = 0; w_cnt = 0; aw_seen = 0; w_seen = 0;
            p_awv = 1'b0; p_wv = 1'b0;
        end else begin
            if (p_awv && (!awvalid || awaddr != p_awaddr)) viol++;
            if (p_wv && (!wvalid || wdata != p_wdata)) viol++;
            if (awvalid && aw_seen != 0) viol++;
            if (wvalid && w_seen != 0) viol++;

            rvalid = r_pend;
            rdata  = {31'h7FFF_FFFF, busy_left != 0};
            rresp  = 2'b00;
            if (r_pend && rready) begin
                r_pend = 1'b0;
                if (busy_left > 0) busy_left--;
            end

            bvalid = b_pend && !cfg_b_hold;
            bresp  = cfg_bresp;
            if (bvalid && bready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_write", 32'd1, 32'd0);
                end else begin
                    chk("wdata", got_wdata, sb.pop_front());
                    chk("awaddr", got_awaddr, TX_A);
                    chk("wstrb", {28'h0, got_wstrb}, 32'h1);
                    chk("aw_beats", aw_seen, 1);
                    chk("w_beats", w_seen, 1);
                end
`ifdef UART_AXI_MASTER_RESP_CHECK_EN
                if (cfg_bresp == 2'b00) exp_sent++;
`else
                exp_sent++;
`endif
                b_pend = 1'b0; aw_seen = 0; w_seen = 0;
            end

            arready = 1'b1;
            if (arvalid) begin
                ar_count++;
                chk("araddr", araddr, STAT_A);
                r_pend = 1'b1;
            end

            awready = awvalid && (aw_cnt >= cfg_aw_wait);
            if (awvalid && awready) begin
                aw_seen++; got_awaddr = awaddr; aw_cnt = 0;
            end else if (awvalid) aw_cnt++;
            else aw_cnt = 0;
            p_awv = awvalid && !awready; p_awaddr = awaddr;

            wready = wvalid && (w_cnt >= cfg_w_wait);
            if (wvalid && wready) begin
                w_seen++; got_wdata = wdata; got_wstrb = wstrb; w_cnt = 0;
            end else if (wvalid) w_cnt++;
            else w_cnt = 0;
            p_wv = wvalid && !wready; p_wdata = wdata;

            if (aw_seen != 0 && w_seen != 0) b_pend = 1'b1;
        end
    end

    typedef struct {
        logic [7:0] data;
        int         polls;
        int         aw_wait;
        int         w_wait;
        logic [1:0] bresp;
        int         lat;
        int         ars;
    } vec_t;

    task automatic send(input vec_t v);
        int cyc;
        int ar_base;
        cfg_aw_wait = v.aw_wait; cfg_w_wait = v.w_wait; cfg_bresp = v.bresp;
        busy_left = v.polls;
        ar_base = ar_count;
        for (int k = 0; k < 100 && !in_ready; k++) @(negedge clk);
        sb.push_back({24'h0, v.data});
`ifdef UART_AXI_MASTER_RESP_CHECK_EN
        if (v.bresp != 2'b00) exp_err = 1'b1;
`endif
        in_data = v.data; in_valid = 1'b1;
        @(posedge clk);
        cyc = 1;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (in_ready) break;
            cyc++;
        end
        chk("latency", cyc, v.lat);
        chk("ar_count", ar_count - ar_base, v.ars);
        chk("sent_count", {16'h0, sent_count}, {16'h0, exp_sent});
`ifdef UART_AXI_MASTER_RESP_CHECK_EN
        chk("err", {31'h0, err}, {31'h0, exp_err});
`endif
    endtask

    vec_t vecs[8];

    initial begin
        int idx;
        // latency = 5 + polls*(POLL_GAP+2) + max(aw_wait, w_wait); POLL_GAP = 4
        vecs[0] = '{8'h41, 0, 0, 0, 2'b00,  5, 1};
        vecs[1] = '{8'h5A, 3, 0, 0, 2'b00, 23, 4};
        vecs[2] = '{8'hA5, 0, 3, 0, 2'b00,  8, 1};
        vecs[3] = '{8'h3C, 0, 0, 3, 2'b00,  8, 1};
        vecs[4] = '{8'hFF, 1, 1, 2, 2'b00, 13, 2};
        vecs[5] = '{8'h00, 0, 1, 1, 2'b00,  6, 1};
        vecs[6] = '{8'hC3, 2, 3, 3, 2'b00, 20, 3};
        vecs[7] = '{8'h96, 0, 0, 0, 2'b10,  5, 1};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'h0, in_ready}, 32'd1);
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_valids", {28'h0, arvalid, awvalid, wvalid, rready}, 32'd0);
        chk("rst_bready", {31'h0, bready}, 32'd0);
        chk("rst_sent", {16'h0, sent_count}, 32'd0);
        chk("rst_araddr", araddr, 32'h0);
        chk("rst_awaddr", awaddr, 32'h0);
        chk("rst_wdata", wdata, 32'h0);
`ifdef UART_AXI_MASTER_RESP_CHECK_EN
        chk("rst_err", {31'h0, err}, 32'd0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 8; i++) send(vecs[i]);
        cfg_bresp = 2'b00;

        // Reset while waiting for the write response
        cfg_b_hold = 1'b1;
        sb.push_back(32'h0000_0077);
        in_data = 8'h77; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bready) break;
        end
        chk("reach_wr_resp", {31'h0, bready}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_in_ready", {31'h0, in_ready}, 32'd1);
        chk("abort_valids", {28'h0, arvalid, awvalid, wvalid, bready}, 32'd0);
        chk("abort_busy", {31'h0, busy}, 32'd0);
        chk("abort_sent", {16'h0, sent_count}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        exp_sent = 16'h0;
        cfg_b_hold = 1'b0;
`ifdef UART_AXI_MASTER_RESP_CHECK_EN
        exp_err = 1'b0;
        chk("err_cleared", {31'h0, err}, 32'd0);
`endif

        // Back-to-back stream 0x00..0xFF
        cfg_aw_wait = 0; cfg_w_wait = 1; busy_left = 2;
        idx = 0; in_data = 8'h00; in_valid = 1'b1;
        for (int k = 0; k < 20000 && idx < 256; k++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back({24'h0, in_data});
                idx++;
                @(posedge clk);
                #1;
                if (idx < 256) in_data = 8'(idx);
                else in_valid = 1'b0;
            end
        end
        chk("stream_accepted", idx, 256);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && in_ready) break;
        end
        chk("stream_drained", sb.size(), 0);
        chk("stream_sent", {16'h0, sent_count}, 32'd256);
        chk("protocol", viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/uart_axi_tx_master.md
# uart_axi_tx_master

AXI4-Lite master that feeds the AXI UART peripheral from a byte stream. Accepts bytes on a valid/ready interface, polls the UART status register until the transmitter is idle, then writes the byte to the TX data register. Sits directly upstream of the UART peripheral's slave port, replacing a processor or VIP master for streaming transmit.

## Interface
- BASE_ADDR, 32'h44A0_0000, UART peripheral base address
- TX_OFFSET, 4'h0, TX data register offset
- STAT_OFFSET, 4'h8, status register offset; bit 0 = TX busy
- POLL_GAP, 4, idle cycles between consecutive status polls (≥1)
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_data  in  8  byte to transmit
- in_valid  in  1  in_data valid
- in_ready  out  1  block can accept a byte
- m_axi_awaddr / awprot / awvalid / awready  out/out/out/in  32/3/1/1  write address channel, awprot = 3'b000
- m_axi_wdata / wstrb / wvalid / wready  out/out/out/in  32/4/1/1  write data channel, wdata = {24'h0, byte}, wstrb = 4'b0001
- m_axi_bresp / bvalid / bready  in/in/out  2/1/1  write response
- m_axi_araddr / arprot / arvalid / arready  out/out/out/in  32/3/1/1  read address, arprot = 3'b000
- m_axi_rdata / rresp / rvalid / rready  in/in/in/out  32/2/1/1  read data
- busy  out  1  transaction in progress (state ≠ IDLE)
- sent_count  out  16  bytes written with completed B, wraps 0xFFFF→0

## Operation
- States: IDLE, RD_ADDR, RD_DATA, GAP, WR, WR_RESP.
- IDLE: in_ready=1. in_valid&in_ready latches in_data → RD_ADDR.
- RD_ADDR: arvalid=1, araddr=BASE_ADDR+STAT_OFFSET; on arready → RD_DATA.
- RD_DATA: rready=1; on rvalid: rdata[0]=1 → GAP; else → WR.
- GAP: counter POLL_GAP−1 down to 0, then → RD_ADDR.
- WR: awvalid and wvalid asserted together, awaddr=BASE_ADDR+TX_OFFSET. Each channel drops its valid independently after its handshake (sticky done flags); leave WR when both done → WR_RESP. Simultaneous awready/wready in one cycle completes both.
- WR_RESP: bready=1; on bvalid → sent_count+1, → IDLE.
- Valids never deasserted before handshake; address/data stable while valid.
- bresp/rresp ignored unless the configuration macro is defined.

## Timing
- Reset: state IDLE, in_ready=1, all valids 0, bready=0, rready=0, busy=0, sent_count=0, addresses/wdata 0, err=0 (if present).
- Reset mid-transaction aborts immediately; outstanding AXI handshake is dropped (slave is reset on the same reset in-system).
- Minimum byte cost with zero-wait slave and idle UART: IDLE(1)+RD_ADDR(1)+RD_DATA(1)+WR(1)+WR_RESP(1) = 5 cycles; in_ready back to 1 on the cycle after bvalid.
- Each busy poll adds POLL_GAP+2 cycles.
- in_ready is registered from state only; no combinational path from AXI inputs to in_ready.

## Configuration
- UART_AXI_MASTER_RESP_CHECK_EN defined: extra output err (1 bit, sticky, cleared by rst only) sets when bresp≠2'b00 or rresp≠2'b00 on handshake; a non-OKAY rresp is treated as busy (re-poll); a non-OKAY bresp does not increment sent_count.
- Undefined: no err port, responses ignored, sent_count increments on every B.

## Structure
- Package uart_axi_pkg: state enum, register offset constants (TX 0x0, RX 0x4, STAT 0x8, CTRL 0xC), status bit index TX_BUSY_BIT=0, AXI_RESP_OKAY=2'b00.
- No sub-module; single FSM with GAP counter and two sticky write-channel flags.

## Test plan
- Idle UART, zero-wait slave, send 0x41 → one AR to 0x44A0_0008, one AW to 0x44A0_0000 with wdata 0x0000_0041, wstrb 0x1; sent_count=1; in_ready returns after 5 cycles.
- Status reads 1 three times then 0, POLL_GAP=4 → exactly 4 ARs, 3 gaps of 4 idle cycles, then one write.
- Slave asserts wready 3 cycles before awready → wvalid drops after its handshake, awvalid held; single bready phase; no duplicate W.
- Stream 0x00..0xFF back-to-back with full UART model (connected to uart_axi, tx_out decoded) → 256 bytes received in order, sent_count=256.
- rst asserted during WR_RESP → next cycle all valids 0, in_ready=1, sent_count=0.
- With UART_AXI_MASTER_RESP_CHECK_EN, bresp=2'b10 → err=1, sent_count unchanged.
